// File: rtl/stream_source_if.sv
// Command and output-beat signals of stream_source, bundled with the source (master)
// and consumer/commander (slave) views.
interface stream_source_if #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned NUM_ELEMENTS = 4,
   parameter int unsigned COUNT_W      = 32
);
   logic                           cmd_valid;
   logic                           cmd_ready;
   logic [DATA_W-1:0]              cmd_start;
   logic [DATA_W-1:0]              cmd_stride;
   logic [COUNT_W-1:0]             cmd_count;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_ELEMENTS*DATA_W-1:0] out_data;
   logic [NUM_ELEMENTS-1:0]        out_keep;
   logic                           out_last;
   logic                           done;

   modport master (
      input  cmd_valid, cmd_start, cmd_stride, cmd_count, out_ready,
      output cmd_ready, out_valid, out_data, out_keep, out_last, done
   );

   modport slave (
      output cmd_valid, cmd_start, cmd_stride, cmd_count, out_ready,
      input  cmd_ready, out_valid, out_data, out_keep, out_last, done
   );
endinterface

// File: rtl/stream_source.sv
// Emits start + g*stride for g in [0, count) as NUM_ELEMENTS-lane beats with keep/last,
// one command at a time.
module stream_source #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned NUM_ELEMENTS = 4,
   parameter int unsigned COUNT_W      = 32
) (
   input logic             clk,
   input logic             rst,
   stream_source_if.master bus
);
   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                         state_q, state_d;
   logic [DATA_W-1:0]              lane_q [NUM_ELEMENTS];
   logic [DATA_W-1:0]              lane_d [NUM_ELEMENTS];
   logic [DATA_W-1:0]              seq_lane [NUM_ELEMENTS];
   logic [DATA_W-1:0]              seq_step, step_q, step_d;
   logic [COUNT_W-1:0]             rem_q, rem_d;
   logic [NUM_ELEMENTS*DATA_W-1:0] data_q, data_d;
   logic [NUM_ELEMENTS-1:0]        keep_q, keep_d;
   logic                           last_q, last_d;
   logic                           done_q, done_d;
   logic                           cmd_ready, accept, beat_hs, load;

   assign cmd_ready = (state_q == StIdle) && !rst;
   assign accept    = bus.cmd_valid && cmd_ready;
   assign beat_hs   = (state_q == StRun) && bus.out_ready;

   assign bus.cmd_ready = cmd_ready;
   assign bus.out_valid = (state_q == StRun);
   assign bus.out_data  = data_q;
   assign bus.out_keep  = keep_q;
   assign bus.out_last  = last_q;
   assign bus.done      = done_q && !rst;

   // Lane seeds start + i*stride and the per-beat step N*stride, built from an adder chain.
   always_comb begin : seq_gen
      logic [DATA_W-1:0] acc;
      acc      = bus.cmd_start;
      seq_step = '0;
      for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
         seq_lane[i] = acc;
         acc         = acc + bus.cmd_stride;
         seq_step    = seq_step + bus.cmd_stride;
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      step_d  = step_q;
      rem_d   = rem_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      done_d  = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
                  lane_d  = seq_lane;
                  step_d  = seq_step;
                  rem_d   = bus.cmd_count;
                  load    = 1'b1;
               end
            end
         end
         StRun: begin
            if (beat_hs) begin
               if (last_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  data_d  = '0;
                  keep_d  = '0;
                  last_d  = 1'b0;
               end else begin
                  // Not last means rem_q > NUM_ELEMENTS, so this cannot underflow.
                  rem_d = rem_q - COUNT_W'(NUM_ELEMENTS);
                  for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
                     lane_d[i] = lane_q[i] + step_q;
                  end
                  load = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            keep_d[i]                   = COUNT_W'(i) < rem_d;
            data_d[i*DATA_W +: DATA_W] = keep_d[i] ? lane_d[i] : '0;
         end
         last_d = rem_d <= COUNT_W'(NUM_ELEMENTS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         done_q  <= done_d;
         lane_q  <= lane_d;
      end
   end
endmodule

// File: tb/tb_stream_source.sv
// Directed and randomized checks of stream_source against an arithmetic model of the
// expected beats; a second 8-bit instance covers data wrap-around.
module tb_stream_source;
   localparam int unsigned DW = 32;
   localparam int unsigned NE = 4;
   localparam int unsigned CW = 32;

   typedef struct {
      logic [NE*DW-1:0] data;
      logic [NE-1:0]    keep;
      logic             last;
   } beat_t;

   logic  clk;
   logic  rst;
   int    total = 0;
   int    bad = 0;
   beat_t exp_q[$];

   stream_source_if #(.DATA_W(DW), .NUM_ELEMENTS(NE), .COUNT_W(CW)) bus ();
   stream_source_if #(.DATA_W(8), .NUM_ELEMENTS(NE), .COUNT_W(CW)) bus8 ();

   stream_source #(.DATA_W(DW), .NUM_ELEMENTS(NE), .COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   stream_source #(.DATA_W(8), .NUM_ELEMENTS(NE), .COUNT_W(CW)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected beats from element g = start + g*stride, present while g < count.
   task automatic build(input logic [31:0] s, input logic [31:0] st, input logic [31:0] c);
      longint unsigned nb;
      longint unsigned g;
      logic [63:0]     v;
      beat_t           b;
      exp_q.delete();
      nb = (longint'(c) + NE - 1) / NE;
      for (longint unsigned bi = 0; bi < nb; bi++) begin
         b.data = '0;
         b.keep = '0;
         for (int unsigned i = 0; i < NE; i++) begin
            g = bi * NE + i;
            if (g < longint'(c)) begin
               v = 64'(s) + g * 64'(st);
               b.keep[i]           = 1'b1;
               b.data[i*DW +: DW] = v[31:0];
            end
         end
         b.last = (bi == nb - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic send_cmd(input logic [31:0] s, input logic [31:0] st, input logic [31:0] c);
      int n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
      bus.cmd_valid  = 1'b1;
      bus.cmd_start  = s;
      bus.cmd_stride = st;
      bus.cmd_count  = c;
      tick();
      bus.cmd_valid  = 1'b0;
      bus.cmd_start  = $urandom;
      bus.cmd_stride = $urandom;
      bus.cmd_count  = $urandom;
   endtask

   task automatic run_cmd(input logic [31:0] s, input logic [31:0] st, input logic [31:0] c,
                          input bit rand_rdy, input int stall_beat);
      int               beat = 0;
      int               cyc = 0;
      int               stall_left = 0;
      bit               stall_armed = 0;
      bit               stalled = 0;
      logic             rdy;
      logic [NE*DW-1:0] hd;
      logic [NE-1:0]    hk;
      logic             hl;
      build(s, st, c);
      send_cmd(s, st, c);
      if (c == 0) begin
         chk("zero_done", 128'(bus.done), 128'(1));
         chk("zero_valid", 128'(bus.out_valid), 128'(0));
         chk("zero_cmd_ready", 128'(bus.cmd_ready), 128'(1));
         tick();
         chk("zero_done_clear", 128'(bus.done), 128'(0));
         chk("zero_valid_after", 128'(bus.out_valid), 128'(0));
         return;
      end
      while (exp_q.size() > 0 && cyc < 400) begin
         if (beat == stall_beat && !stall_armed) begin
            stall_left  = 5;
            stall_armed = 1;
         end
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         bus.out_ready = rdy;
         chk("valid_run", 128'(bus.out_valid), 128'(1));
         chk("cmd_ready_run", 128'(bus.cmd_ready), 128'(0));
         if (stalled) begin
            chk("hold_data", 128'(bus.out_data), 128'(hd));
            chk("hold_keep", 128'(bus.out_keep), 128'(hk));
            chk("hold_last", 128'(bus.out_last), 128'(hl));
         end
         if (rdy) begin
            chk($sformatf("beat%0d_data", beat), 128'(bus.out_data), 128'(exp_q[0].data));
            chk($sformatf("beat%0d_keep", beat), 128'(bus.out_keep), 128'(exp_q[0].keep));
            chk($sformatf("beat%0d_last", beat), 128'(bus.out_last), 128'(exp_q[0].last));
            void'(exp_q.pop_front());
            beat++;
            stalled = 0;
         end else begin
            stalled = 1;
            hd = bus.out_data;
            hk = bus.out_keep;
            hl = bus.out_last;
         end
         tick();
         cyc++;
      end
      bus.out_ready = 1'b0;
      chk("beats_left", 128'(exp_q.size()), 128'(0));
      chk("end_done", 128'(bus.done), 128'(1));
      chk("end_valid", 128'(bus.out_valid), 128'(0));
      chk("end_cmd_ready", 128'(bus.cmd_ready), 128'(1));
      tick();
      chk("end_done_clear", 128'(bus.done), 128'(0));
   endtask

   initial begin
      rst             = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_start   = '0;
      bus.cmd_stride  = '0;
      bus.cmd_count   = '0;
      bus.out_ready   = 1'b0;
      bus8.cmd_valid  = 1'b0;
      bus8.cmd_start  = '0;
      bus8.cmd_stride = '0;
      bus8.cmd_count  = '0;
      bus8.out_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(0));
      chk("rst_done", 128'(bus.done), 128'(0));
      chk("rst_keep", 128'(bus.out_keep), 128'(0));
      chk("rst_last", 128'(bus.out_last), 128'(0));
      chk("rst_data", 128'(bus.out_data), 128'(0));
      rst = 1'b0;
      tick();
      chk("idle_cmd_ready", 128'(bus.cmd_ready), 128'(1));

      run_cmd(32'd100, 32'd1, 32'd10, 1'b0, -1);
      run_cmd(32'd5, 32'd5, 32'd0, 1'b0, -1);
      run_cmd(32'd7, 32'd2, 32'd4, 1'b0, -1);
      run_cmd(32'd100, 32'd1, 32'd10, 1'b1, 1);

      // 8-bit lanes: 250, 253, 256->0, 259->3.
      chk("w8_cmd_ready", 128'(bus8.cmd_ready), 128'(1));
      bus8.cmd_valid  = 1'b1;
      bus8.cmd_start  = 8'd250;
      bus8.cmd_stride = 8'd3;
      bus8.cmd_count  = 32'd4;
      tick();
      bus8.cmd_valid = 1'b0;
      chk("w8_valid", 128'(bus8.out_valid), 128'(1));
      chk("w8_data", 128'(bus8.out_data), 128'(32'h0300_FDFA));
      chk("w8_keep", 128'(bus8.out_keep), 128'(4'hF));
      chk("w8_last", 128'(bus8.out_last), 128'(1));
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      chk("w8_done", 128'(bus8.done), 128'(1));
      chk("w8_valid_end", 128'(bus8.out_valid), 128'(0));

      // Abandon a run after beat 0 by reset.
      build(32'd100, 32'd1, 32'd10);
      send_cmd(32'd100, 32'd1, 32'd10);
      bus.out_ready = 1'b1;
      chk("mr_beat0_data", 128'(bus.out_data), 128'(exp_q[0].data));
      tick();
      bus.out_ready = 1'b0;
      chk("mr_valid_pre", 128'(bus.out_valid), 128'(1));
      rst = 1'b1;
      tick();
      chk("mr_valid", 128'(bus.out_valid), 128'(0));
      chk("mr_cmd_ready", 128'(bus.cmd_ready), 128'(0));
      chk("mr_last", 128'(bus.out_last), 128'(0));
      chk("mr_keep", 128'(bus.out_keep), 128'(0));
      chk("mr_data", 128'(bus.out_data), 128'(0));
      chk("mr_done", 128'(bus.done), 128'(0));
      tick();
      chk("mr_cmd_ready2", 128'(bus.cmd_ready), 128'(0));
      rst = 1'b0;
      tick();
      chk("mr_cmd_ready_rel", 128'(bus.cmd_ready), 128'(1));
      chk("mr_valid_rel", 128'(bus.out_valid), 128'(0));
      run_cmd(32'd20, 32'd1, 32'd2, 1'b0, -1);

      for (int k = 0; k < 25; k++) begin
         run_cmd($urandom, $urandom, 32'($urandom_range(0, 21)), 1'b1, -1);
      end
      run_cmd(32'hFFFF_FFFA, 32'd3, 32'd9, 1'b1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
